entrada_controle: RTL and testbench

- Input-stall controller. It sits downstream of the control unit and consumes its In[1:0] select.
- While an IN (In=1) or keyboard-read (In=2) instruction is decoded, the processor clock enable is held low by the control unit. This block waits for a debounced button press/release or a keyboard byte.
- It presents the captured value on InData for the register-file write mux, then pulses Release so the stalled instruction retires and the PC advances.
- A one-entry keyboard buffer holds bytes that arrive while no read is pending.

---
 rtl/entrada_controle.sv | 167 ++++++++++++++++
 tb/tb_entrada_controle.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/entrada_controle.sv
// Input-stall controller: waits for a debounced button press/release or a keyboard
// byte while IN / keyboard-read is decoded, presents the value on InData, pulses Release.
module entrada_controle #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned SW_WIDTH        = 16,
  parameter int unsigned KB_WIDTH        = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            In,
  input  logic                  Button,
  input  logic [SW_WIDTH-1:0]   Switches,
  input  logic [KB_WIDTH-1:0]   KbData,
  input  logic                  KbValid,
  output logic [DATA_WIDTH-1:0] InData,
  output logic                  Release,
  output logic                  Waiting,
  output logic                  KbOverrun
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PRESS,
    WAIT_RELEASE,
    WAIT_KB,
    DONE
  } state_t;

  state_t state, next_state;

  logic [1:0]            sync;
  logic                  bsync;
  logic                  db;
  logic [CNT_W-1:0]      cnt;
  logic                  db_toggle;
  logic                  rise;
  logic                  fall;

  logic [KB_WIDTH-1:0]   kb_buf;
  logic                  pending;
  logic                  buf_load;

  logic                  abort;
  logic                  capture;
  logic [DATA_WIDTH-1:0] capture_val;
  logic                  consume;

  assign bsync = sync[1];

  // rise/fall coincide with the edge on which db toggles
  assign db_toggle = (bsync != db) && (cnt == CNT_LAST);
  assign rise      = db_toggle && !db;
  assign fall      = db_toggle && db;

  assign abort    = (In == 2'd0) || (In == 2'd3);
  assign buf_load = KbValid && (state != WAIT_KB);

  // Synchronizer and debounce counter
  always_ff @(posedge clock) begin
    if (reset) begin
      sync <= 2'b00;
      cnt  <= '0;
      db   <= 1'b0;
    end else begin
      sync <= {sync[0], Button};
      if (bsync == db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt <= '0;
        db  <= ~db;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // State register, registered outputs and keyboard buffer
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      InData    <= '0;
      Release   <= 1'b0;
      Waiting   <= 1'b0;
      KbOverrun <= 1'b0;
      kb_buf    <= '0;
      pending   <= 1'b0;
    end else begin
      state   <= next_state;
      Release <= (next_state == DONE);
      Waiting <= (next_state == WAIT_PRESS) || (next_state == WAIT_RELEASE) ||
                 (next_state == WAIT_KB);
      if (capture) begin
        InData <= capture_val;
      end
      // A byte arriving as the old one is consumed refills the buffer without overrun
      if (buf_load) begin
        kb_buf  <= KbData;
        pending <= 1'b1;
        if (pending && !consume) begin
          KbOverrun <= 1'b1;
        end
      end else if (consume) begin
        pending <= 1'b0;
      end
    end
  end

  // Next-state and capture decode
  always_comb begin
    next_state  = state;
    capture     = 1'b0;
    capture_val = '0;
    consume     = 1'b0;
    case (state)
      IDLE: begin
        if (In == 2'd1) begin
          next_state = WAIT_PRESS;
        end else if (In == 2'd2) begin
          if (pending) begin
            capture     = 1'b1;
            capture_val = DATA_WIDTH'(kb_buf);
            consume     = 1'b1;
            next_state  = DONE;
          end else begin
            next_state = WAIT_KB;
          end
        end
      end
      WAIT_PRESS: begin
        if (abort) begin
          next_state = IDLE;
        end else if (rise) begin
          capture     = 1'b1;
          capture_val = DATA_WIDTH'(Switches);
          next_state  = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        if (abort) begin
          next_state = IDLE;
        end else if (fall) begin
          next_state = DONE;
        end
      end
      WAIT_KB: begin
        if (abort) begin
          next_state = IDLE;
        end else if (KbValid) begin
          capture     = 1'b1;
          capture_val = DATA_WIDTH'(KbData);
          next_state  = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_entrada_controle.sv
// Directed bench for entrada_controle: button IN with debounce, held button,
// keyboard buffer/overrun, keyboard wait, abort and mid-wait reset.
module tb_entrada_controle;

  logic        clock;
  logic        reset;
  logic [1:0]  In;
  logic        Button;
  logic [15:0] Switches;
  logic [7:0]  KbData;
  logic        KbValid;
  logic [31:0] InData;
  logic        Release;
  logic        Waiting;
  logic        KbOverrun;

  int checks = 0;
  int errors = 0;
  int rel_cnt = 0;

  entrada_controle #(
    .DATA_WIDTH(32),
    .SW_WIDTH(16),
    .KB_WIDTH(8),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .In(In),
    .Button(Button),
    .Switches(Switches),
    .KbData(KbData),
    .KbValid(KbValid),
    .InData(InData),
    .Release(Release),
    .Waiting(Waiting),
    .KbOverrun(KbOverrun)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Count Release pulses between clock edges
  always @(negedge clock) begin
    if (Release === 1'b1) rel_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Drop the button and expect Release on the edge where db falls
  task automatic finish_release(input string tag, input int exp_rel);
    Button = 1'b0;
    step(5);
    check({tag, "_rel_before"}, 32'(Release), 32'd0);
    step(1);
    check({tag, "_rel_pulse"}, 32'(Release), 32'd1);
    check({tag, "_wait_done"}, 32'(Waiting), 32'd0);
    In = 2'd0;
    step(1);
    check({tag, "_rel_after"}, 32'(Release), 32'd0);
    check({tag, "_wait_after"}, 32'(Waiting), 32'd0);
    check({tag, "_rel_count"}, 32'(rel_cnt), 32'(exp_rel));
  endtask

  initial begin
    reset = 1'b1; In = 2'd0; Button = 1'b0; Switches = 16'h0000;
    KbData = 8'h00; KbValid = 1'b0;
    step(2);
    reset = 1'b0;
    step(1);
    check("rst_indata", InData, 32'h0);
    check("rst_release", 32'(Release), 32'd0);
    check("rst_waiting", 32'(Waiting), 32'd0);
    check("rst_overrun", 32'(KbOverrun), 32'd0);

    // Clean press: capture 6 edges after press
    In = 2'd1; Switches = 16'hBEEF;
    step(1);
    check("t1_waiting", 32'(Waiting), 32'd1);
    Button = 1'b1;
    step(5);
    check("t1_pre_capture", InData, 32'h0);
    step(1);
    check("t1_capture", InData, 32'h0000BEEF);
    step(4);
    check("t1_wait_release", 32'(Waiting), 32'd1);
    finish_release("t1", 1);

    // Bouncing button: only one capture once stable
    In = 2'd1; Switches = 16'h1234;
    step(1);
    for (int i = 0; i < 6; i++) begin
      Button = (i % 2 == 0) ? 1'b1 : 1'b0;
      step(2);
    end
    check("t2_no_capture_bounce", InData, 32'h0000BEEF);
    Button = 1'b1;
    step(5);
    check("t2_pre_capture", InData, 32'h0000BEEF);
    step(1);
    check("t2_capture", InData, 32'h00001234);
    step(4);
    finish_release("t2", 2);

    // Button already held when IN arrives
    Button = 1'b1;
    step(8);
    Switches = 16'hCAFE; In = 2'd1;
    step(1);
    step(10);
    check("t3_held_no_capture", InData, 32'h00001234);
    check("t3_held_waiting", 32'(Waiting), 32'd1);
    Button = 1'b0;
    step(8);
    check("t3_fall_no_release", 32'(rel_cnt), 32'd2);
    check("t3_still_waiting", 32'(Waiting), 32'd1);
    Switches = 16'hF00D;
    Button = 1'b1;
    step(5);
    check("t3_pre_capture", InData, 32'h00001234);
    step(1);
    check("t3_capture", InData, 32'h0000F00D);
    step(4);
    finish_release("t3", 3);

    // Two bytes while idle: overrun, latest wins
    KbData = 8'h41; KbValid = 1'b1;
    step(1);
    KbValid = 1'b0;
    check("t4_no_overrun", 32'(KbOverrun), 32'd0);
    step(2);
    KbData = 8'h42; KbValid = 1'b1;
    step(1);
    KbValid = 1'b0;
    check("t4_overrun", 32'(KbOverrun), 32'd1);
    In = 2'd2;
    step(1);
    check("t4_indata", InData, 32'h00000042);
    check("t4_release", 32'(Release), 32'd1);
    In = 2'd0;
    step(1);
    check("t4_rel_after", 32'(Release), 32'd0);
    check("t4_rel_count", 32'(rel_cnt), 32'd4);

    // Empty buffer: wait for keyboard byte
    In = 2'd2;
    step(1);
    check("t5_waiting", 32'(Waiting), 32'd1);
    check("t5_pending_cleared", 32'(Release), 32'd0);
    step(5);
    check("t5_still_waiting", 32'(Waiting), 32'd1);
    KbData = 8'h0D; KbValid = 1'b1;
    step(1);
    KbValid = 1'b0;
    check("t5_indata", InData, 32'h0000000D);
    check("t5_release", 32'(Release), 32'd1);
    In = 2'd0;
    step(1);
    check("t5_rel_after", 32'(Release), 32'd0);
    In = 2'd2;
    step(1);
    check("t5_buf_empty", 32'(Waiting), 32'd1);
    In = 2'd0;
    step(1);
    check("t5_abort_wait", 32'(Waiting), 32'd0);
    check("t5_abort_indata", InData, 32'h0000000D);
    check("t5_abort_rel", 32'(rel_cnt), 32'd5);

    // Reset during WAIT_RELEASE
    In = 2'd1; Switches = 16'h7777;
    step(1);
    Button = 1'b1;
    step(6);
    check("t6_capture", InData, 32'h00007777);
    check("t6_waiting", 32'(Waiting), 32'd1);
    reset = 1'b1; In = 2'd3;
    step(1);
    reset = 1'b0;
    check("t6_rst_indata", InData, 32'h0);
    check("t6_rst_waiting", 32'(Waiting), 32'd0);
    check("t6_rst_release", 32'(Release), 32'd0);
    check("t6_rst_overrun", 32'(KbOverrun), 32'd0);
    Button = 1'b0;
    step(3);
    check("t6_in3_idle", 32'(Waiting), 32'd0);
    check("t6_rel_count", 32'(rel_cnt), 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
